// File: rtl/if_pkg.sv
// Shared types and widths for the instruction-fetch stage.
package if_pkg;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned INSTR_W = 32;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    FULL  = 2'd1,
    DRAIN = 2'd2
  } if_state_t;
endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load captures a new instruction, clear drops valid only.
module if_id_reg
  import if_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               clear,
  input  logic [ADDR_W-1:0]  load_pc,
  input  logic [INSTR_W-1:0] load_instr,
  output logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] instr,
  output logic               valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= '0;
      instr <= '0;
      valid <= 1'b0;
    end else if (load) begin
      pc    <= load_pc;
      instr <= load_instr;
      valid <= 1'b1;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding request, one-entry skid buffer, redirect drain.
module if_stage
  import if_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               freeze,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_addr,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0]  id_pc,
  output logic [INSTR_W-1:0] id_instr,
  output logic               id_valid
);

  if_state_t          state, state_n;
  logic [ADDR_W-1:0]  pc, pc_n, pc_inc;
  logic [ADDR_W-1:0]  buf_pc, buf_pc_n, drain_addr, drain_addr_n;
  logic [INSTR_W-1:0] buf_instr, buf_instr_n;
  logic               id_load, id_clear;
  logic [ADDR_W-1:0]  id_load_pc;
  logic [INSTR_W-1:0] id_load_instr;

  assign pc_inc    = pc + 1'b1;
  assign imem_req  = (state != FULL);
  assign imem_addr = (state == DRAIN) ? drain_addr : pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      buf_pc     <= '0;
      buf_instr  <= '0;
      drain_addr <= '0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      buf_pc     <= buf_pc_n;
      buf_instr  <= buf_instr_n;
      drain_addr <= drain_addr_n;
    end
  end

  always_comb begin
    state_n       = state;
    pc_n          = pc;
    buf_pc_n      = buf_pc;
    buf_instr_n   = buf_instr;
    drain_addr_n  = drain_addr;
    id_load       = 1'b0;
    id_clear      = 1'b0;
    id_load_pc    = pc_inc;
    id_load_instr = imem_rdata;
    if (branch_taken) begin
      // Redirect wins over freeze and ack; an unacked request must still complete, so drain it.
      pc_n     = branch_addr;
      id_clear = 1'b1;
      unique case (state)
        FETCH: begin
          if (imem_ack) begin
            state_n = FETCH;
          end else begin
            state_n      = DRAIN;
            drain_addr_n = pc;
          end
        end
        FULL:    state_n = FETCH;
        DRAIN:   state_n = imem_ack ? FETCH : DRAIN;
        default: state_n = FETCH;
      endcase
    end else begin
      unique case (state)
        FETCH: begin
          if (imem_ack) begin
            pc_n = pc_inc;
            if (freeze) begin
              buf_pc_n    = pc_inc;
              buf_instr_n = imem_rdata;
              state_n     = FULL;
            end else begin
              id_load = 1'b1;
            end
          end else if (!freeze) begin
            id_clear = 1'b1;
          end
        end
        FULL: begin
          if (!freeze) begin
            id_load       = 1'b1;
            id_load_pc    = buf_pc;
            id_load_instr = buf_instr;
            state_n       = FETCH;
          end
        end
        DRAIN: begin
          if (imem_ack) state_n = FETCH;
          if (!freeze) id_clear = 1'b1;
        end
        default: state_n = FETCH;
      endcase
    end
  end

  if_id_reg u_if_id_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (id_load),
    .clear      (id_clear),
    .load_pc    (id_load_pc),
    .load_instr (id_load_instr),
    .pc         (id_pc),
    .instr      (id_instr),
    .valid      (id_valid)
  );

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus a randomized stream check.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        id_valid;

  int n_tests = 0;
  int n_fail  = 0;

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .id_pc        (id_pc),
    .id_instr     (id_instr),
    .id_valid     (id_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
  endfunction

  task automatic step(input logic br, input logic [31:0] ba, input logic frz, input logic ack);
    branch_taken = br;
    branch_addr  = ba;
    freeze       = frz;
    imem_ack     = ack;
    imem_rdata   = ack ? mem(imem_addr) : 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; freeze = 1'b0; branch_taken = 1'b0; imem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({id_valid, id_pc, id_instr} !== 65'd0) begin
      n_fail++; $display("FAIL reset_id: got v=%b pc=%h instr=%h, expected all zero", id_valid, id_pc, id_instr);
    end
    n_tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_fail++; $display("FAIL reset_req: got req=%b addr=%h, expected req=1 addr=0", imem_req, imem_addr);
    end
    do_reset();
  endtask

  task automatic test_stream();
    for (int unsigned i = 0; i < 4; i++) begin
      n_tests++;
      if (imem_addr !== 32'(i)) begin
        n_fail++; $display("FAIL stream_addr%0d: got %h expected %h", i, imem_addr, 32'(i));
      end
      step(1'b0, '0, 1'b0, 1'b1);
      n_tests++;
      if (id_valid !== 1'b1 || id_pc !== 32'(i + 1) || id_instr !== mem(32'(i))) begin
        n_fail++; $display("FAIL stream_id%0d: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                           i, id_valid, id_pc, id_instr, 32'(i + 1), mem(32'(i)));
      end
    end
  endtask

  task automatic test_freeze();
    step(1'b0, '0, 1'b0, 1'b1);  // addr 4 delivered
    n_tests++;
    if (imem_addr !== 32'd5) begin
      n_fail++; $display("FAIL freeze_pre_addr: got %h expected 5", imem_addr);
    end
    for (int unsigned c = 0; c < 3; c++) begin
      step(1'b0, '0, 1'b1, c == 0);
      n_tests++;
      if (imem_req !== 1'b0 || id_valid !== 1'b1 || id_pc !== 32'd5 || id_instr !== mem(32'd4)) begin
        n_fail++; $display("FAIL freeze_hold%0d: got req=%b v=%b pc=%h expected req=0 v=1 pc=5", c, imem_req, id_valid, id_pc);
      end
    end
    step(1'b0, '0, 1'b0, 1'b0);
    n_tests++;
    if (id_valid !== 1'b1 || id_pc !== 32'd6 || id_instr !== mem(32'd5) || imem_req !== 1'b1 || imem_addr !== 32'd6) begin
      n_fail++; $display("FAIL freeze_release: got v=%b pc=%h req=%b addr=%h expected v=1 pc=6 req=1 addr=6", id_valid, id_pc, imem_req, imem_addr);
    end
  endtask

  task automatic test_branch_drain();
    step(1'b0, '0, 1'b0, 1'b1);  // addr 6 delivered, addr 7 outstanding
    step(1'b1, 32'h40, 1'b0, 1'b0);
    n_tests++;
    if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'd7) begin
      n_fail++; $display("FAIL drain_hold: got v=%b req=%b addr=%h expected v=0 req=1 addr=7", id_valid, imem_req, imem_addr);
    end
    step(1'b0, '0, 1'b0, 1'b1);
    n_tests++;
    if (id_valid !== 1'b0 || imem_addr !== 32'h40) begin
      n_fail++; $display("FAIL drain_discard: got v=%b addr=%h expected v=0 addr=40", id_valid, imem_addr);
    end
    step(1'b0, '0, 1'b0, 1'b1);
    n_tests++;
    if (id_valid !== 1'b1 || id_pc !== 32'h41 || id_instr !== mem(32'h40)) begin
      n_fail++; $display("FAIL drain_target: got v=%b pc=%h expected v=1 pc=41", id_valid, id_pc);
    end
  endtask

  task automatic test_branch_full();
    step(1'b0, '0, 1'b1, 1'b1);  // addr 41 buffered
    step(1'b1, 32'h80, 1'b1, 1'b0);
    n_tests++;
    if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h80) begin
      n_fail++; $display("FAIL full_branch: got v=%b req=%b addr=%h expected v=0 req=1 addr=80", id_valid, imem_req, imem_addr);
    end
    step(1'b0, '0, 1'b0, 1'b1);
    n_tests++;
    if (id_valid !== 1'b1 || id_pc !== 32'h81) begin
      n_fail++; $display("FAIL full_branch_next: got v=%b pc=%h expected v=1 pc=81", id_valid, id_pc);
    end
  endtask

  task automatic test_wrap();
    step(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    n_tests++;
    if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== mem(32'hFFFF_FFFF) || imem_addr !== 32'h0) begin
      n_fail++; $display("FAIL wrap: got v=%b pc=%h addr=%h expected v=1 pc=0 addr=0", id_valid, id_pc, imem_addr);
    end
  endtask

  task automatic test_reset_drain();
    step(1'b0, '0, 1'b0, 1'b1);  // addr 0 delivered, addr 1 outstanding
    step(1'b1, 32'h100, 1'b0, 1'b0);
    n_tests++;
    if (imem_addr !== 32'd1) begin
      n_fail++; $display("FAIL rst_drain_pre: got %h expected 1", imem_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (id_valid !== 1'b0 || id_pc !== 32'h0 || id_instr !== 32'h0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_fail++; $display("FAIL rst_async: got v=%b pc=%h instr=%h req=%b addr=%h expected zeros, req=1", id_valid, id_pc, id_instr, imem_req, imem_addr);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1'b0, '0, 1'b0, 1'b1);
    n_tests++;
    if (id_valid !== 1'b1 || id_pc !== 32'h1 || id_instr !== mem(32'h0)) begin
      n_fail++; $display("FAIL rst_first_fetch: got v=%b pc=%h instr=%h expected v=1 pc=1 instr=%h", id_valid, id_pc, id_instr, mem(32'h0));
    end
  endtask

  // Stream-level model: every live ack enqueues one instruction; delivery pops it in order.
  task automatic test_random();
    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_instr_q[$];
    logic [31:0] next_fetch = 32'h0;
    logic        stale = 1'b0;
    logic        br, frz, ack, p_req, p_v;
    logic [31:0] ba, p_addr, p_pc, p_instr;
    do_reset();
    for (int unsigned cyc = 0; cyc < 3000; cyc++) begin
      br  = ($urandom_range(0, 15) == 0);
      ba  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - $urandom_range(0, 3)) : $urandom;
      frz = ($urandom_range(0, 2) == 0);
      ack = imem_req && ($urandom_range(0, 1) == 1);
      p_req = imem_req; p_addr = imem_addr; p_v = id_valid; p_pc = id_pc; p_instr = id_instr;
      if (exp_pc_q.size() != 0) begin
        n_tests++;
        if (imem_req !== 1'b0) begin
          n_fail++; $display("FAIL rnd_req_when_full c%0d: got req=%b expected 0", cyc, imem_req);
        end
      end
      if (ack && !br && !stale) begin
        n_tests++;
        if (p_addr !== next_fetch) begin
          n_fail++; $display("FAIL rnd_fetch_addr c%0d: got %h expected %h", cyc, p_addr, next_fetch);
        end
        exp_pc_q.push_back(next_fetch + 32'd1);
        exp_instr_q.push_back(mem(next_fetch));
        next_fetch = next_fetch + 32'd1;
      end
      if (ack) stale = 1'b0;
      else if (br && p_req) stale = 1'b1;
      step(br, ba, frz, ack);
      if (br) begin
        exp_pc_q.delete(); exp_instr_q.delete();
        next_fetch = ba;
        n_tests++;
        if (id_valid !== 1'b0) begin
          n_fail++; $display("FAIL rnd_branch_valid c%0d: got %b expected 0", cyc, id_valid);
        end
      end else if (frz) begin
        n_tests++;
        if (id_valid !== p_v || id_pc !== p_pc || id_instr !== p_instr) begin
          n_fail++; $display("FAIL rnd_freeze_hold c%0d: got v=%b pc=%h expected v=%b pc=%h", cyc, id_valid, id_pc, p_v, p_pc);
        end
      end else if (exp_pc_q.size() != 0) begin
        n_tests++;
        if (id_valid !== 1'b1 || id_pc !== exp_pc_q[0] || id_instr !== exp_instr_q[0]) begin
          n_fail++; $display("FAIL rnd_deliver c%0d: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                             cyc, id_valid, id_pc, id_instr, exp_pc_q[0], exp_instr_q[0]);
        end
        void'(exp_pc_q.pop_front()); void'(exp_instr_q.pop_front());
      end else begin
        n_tests++;
        if (id_valid !== 1'b0) begin
          n_fail++; $display("FAIL rnd_bubble c%0d: got v=%b expected 0", cyc, id_valid);
        end
      end
      if (p_req && !ack) begin
        n_tests++;
        if (imem_req !== 1'b1 || imem_addr !== p_addr) begin
          n_fail++; $display("FAIL rnd_req_stable c%0d: got req=%b addr=%h expected req=1 addr=%h", cyc, imem_req, imem_addr, p_addr);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_freeze();
    test_branch_drain();
    test_branch_full();
    test_wrap();
    test_reset_drain();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 clk  input  1  Single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  Asynchronous, active-low reset.
REQ-004 freeze  input  1  Hazard stall from the decode stage; the IF/ID outputs SHALL hold while high.
REQ-005 branch_taken  input  1  Redirect request, single-cycle pulse.
REQ-006 branch_addr  input  32  Redirect target; valid when branch_taken is high.
REQ-007 imem_req  output  1  Instruction memory read request.
REQ-008 imem_addr  output  32  Word address of the outstanding request.
REQ-009 imem_ack  input  1  Single-cycle completion; may arrive in the same cycle as imem_req.
REQ-010 imem_rdata  input  32  Instruction word; valid when imem_ack is high.
REQ-011 id_pc  output  32  Registered address of the fetched instruction plus 1 (word addressing).
REQ-012 id_instr  output  32  Registered instruction word.
REQ-013 id_valid  output  1  Registered flag: id_pc and id_instr hold a live instruction.

Function
REQ-014 The FSM SHALL have three states:
- FETCH: request outstanding, buffer empty.
- FULL: one instruction buffered, no request.
- DRAIN: stale request outstanding after a redirect.
REQ-015 Request outputs:
- imem_req SHALL be 1 in FETCH and DRAIN, and 0 in FULL.
- imem_addr SHALL be pc in FETCH and drain_addr in DRAIN.
- imem_req and imem_addr SHALL stay stable until imem_ack.
REQ-016 All PC arithmetic is modulo 2^32: pc+1 from 32'hFFFF_FFFF wraps to 0.
REQ-017 FETCH, imem_ack, no branch, freeze=0:
- id_pc<=pc+1, id_instr<=imem_rdata, id_valid<=1.
- pc<=pc+1; stay in FETCH.
REQ-018 FETCH, imem_ack, no branch, freeze=1:
- buf_pc<=pc+1, buf_instr<=imem_rdata.
- pc<=pc+1; go to FULL.
- id_* hold.
REQ-019 FETCH, no ack, no branch: if freeze=0, id_valid<=0 (bubble); if freeze=1, id_* hold.
REQ-020 FULL, no branch, freeze=0:
- id_pc<=buf_pc, id_instr<=buf_instr, id_valid<=1.
- go to FETCH.
REQ-021 FULL, no branch, freeze=1: all state holds.
REQ-022 branch_taken SHALL take priority over freeze and ack:
- pc<=branch_addr, id_valid<=0.
- Any buffered instruction is discarded.
- Any imem_rdata returned in the same cycle is discarded.
REQ-023 State after a branch:
- FETCH with ack in the same cycle -> FETCH.
- FETCH without ack -> DRAIN, with drain_addr<=the old pc.
- FULL -> FETCH.
- DRAIN with ack -> FETCH.
- DRAIN without ack -> DRAIN, with drain_addr unchanged.
REQ-024 DRAIN, no branch: on imem_ack, discard the data and go to FETCH; id_valid<=0 unless freeze=1, in which case id_* hold.
REQ-025 No instruction SHALL be lost, duplicated or reordered between redirects.

Reset
REQ-026 While rst_n=0, all of the following SHALL hold regardless of clk:
- pc=RESET_PC, state=FETCH.
- id_pc=0, id_instr=0, id_valid=0.
- buf_pc=0, buf_instr=0, drain_addr=0.
REQ-027 Reset asserted mid-request SHALL abandon the request; the first post-reset request SHALL use address RESET_PC.

Structure
REQ-028 Shared package if_pkg SHALL hold:
- the state encoding (2-bit typedef: FETCH, FULL, DRAIN);
- the constants ADDR_W=32 and INSTR_W=32.
REQ-029 The IF/ID register SHALL be a sub-module, if_id_reg, with async active-low reset, a load enable and a valid-clear input.

Verification
REQ-030 Reset, then imem_ack on every cycle with freeze=0:
- imem_addr 0,1,2,3;
- id_pc 1,2,3,4, each with id_valid=1 one cycle after its ack.
REQ-031 freeze=1 for 3 cycles while an ack for addr 5 arrives:
- state=FULL, imem_req=0, id_* unchanged.
- After release, id_pc=6 and then fetch resumes at addr 6.
REQ-032 branch_taken, branch_addr=32'h40 while the addr-7 request is outstanding with no ack:
- state=DRAIN, imem_addr stays 7.
- The ack data is discarded; the next request is at addr 32'h40 and id_pc=32'h41.
REQ-033 branch_taken and freeze=1 in the same cycle while FULL:
- buffer dropped, id_valid=0, next imem_addr=branch_addr.
REQ-034 pc=32'hFFFF_FFFF with an ack:
- id_pc=0, next imem_addr=0.
REQ-035 rst_n pulsed low asynchronously mid-DRAIN:
- outputs go to reset values immediately;
- first request after release is at RESET_PC.
